// File: rtl/framebuffer_write_arbiter_if.sv
// Write-only AXI4 bundle (AW, W, B channels) of LANES side-by-side ports.
// The arbiter is the slave of the writers' bundle and the master of the memory-side bundle.
interface framebuffer_write_arbiter_if #(
    parameter int LANES  = 1,
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [LANES*ID_W-1:0]   awid;
    logic [LANES*ADDR_W-1:0] awaddr;
    logic [LANES*8-1:0]      awlen;
    logic [LANES*3-1:0]      awsize;
    logic [LANES*2-1:0]      awburst;
    logic [LANES-1:0]        awvalid;
    logic [LANES-1:0]        awready;
    logic [LANES*DATA_W-1:0] wdata;
    logic [LANES*STRB_W-1:0] wstrb;
    logic [LANES-1:0]        wlast;
    logic [LANES-1:0]        wvalid;
    logic [LANES-1:0]        wready;
    logic [LANES*ID_W-1:0]   bid;
    logic [LANES*2-1:0]      bresp;
    logic [LANES-1:0]        bvalid;
    logic [LANES-1:0]        bready;

    // Every channel obeys AXI valid/ready: a beat transfers on a clock edge where
    // valid and ready are both high.
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 write master between NUM_PORTS
// framebuffer writers; tags IDs with the port index and routes B responses back.
module framebuffer_write_arbiter #(
    parameter int NUM_PORTS       = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      aclk,
    input  logic                      resetn,
    framebuffer_write_arbiter_if.slave  s_axi,
    framebuffer_write_arbiter_if.master m_axi,
    output logic                      idle
);
    localparam int PORT_LG    = $clog2(NUM_PORTS);
    localparam int M_ID_WIDTH = ID_WIDTH + PORT_LG;
    localparam int CNT_W      = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PORT_LG:0]   PORT_LIMIT = (PORT_LG + 1)'(NUM_PORTS);
    localparam logic [2:0]         AXSIZE     = 3'($clog2(STRB_WIDTH));

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_PORTS-1:0]    elig;
    logic [NUM_PORTS-1:0]    grant_oh;
    logic                    grant_vld;
    logic                    grant_fire;
    logic [PORT_LG-1:0]      grant_idx;
    logic [PORT_LG-1:0]      ptr_q;
    logic [CNT_W-1:0]        cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]        cnt_d [NUM_PORTS];
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic [M_ID_WIDTH-1:0]   awid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    idle_q, idle_d;
    logic [PORT_LG-1:0]      b_port;
    logic                    b_port_ok;
    logic                    b_hs;
    logic [NUM_PORTS-1:0]    b_dec;

    // A port is only considered with AW and W presented together and room left in its budget.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig[p] = s_axi.awvalid[p] && s_axi.wvalid[p] && (cnt_q[p] < CNT_MAX);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            int p;
            p = int'(ptr_q) + i;
            if (p >= NUM_PORTS) p = p - NUM_PORTS;
            if (!grant_vld && elig[p]) begin
                grant_vld = 1'b1;
                grant_idx = PORT_LG'(p);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        grant_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    grant_fire = 1'b1;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axi.awready) awvalid_d = 1'b0;
                if (m_axi.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_oh = '0;
        if (grant_fire) grant_oh[grant_idx] = 1'b1;
    end

    assign s_axi.awready = grant_oh;
    assign s_axi.wready  = grant_oh;

    // Responses carry the owning port in the ID bits above the writer's own ID.
    assign b_port    = m_axi.bid[ID_WIDTH +: PORT_LG];
    assign b_port_ok = {1'b0, b_port} < PORT_LIMIT;

    always_comb begin
        s_axi.bvalid = '0;
        m_axi.bready = 1'b1;
        if (b_port_ok) begin
            s_axi.bvalid[b_port] = m_axi.bvalid;
            m_axi.bready         = s_axi.bready[b_port];
        end
    end

    assign s_axi.bid   = {NUM_PORTS{m_axi.bid[ID_WIDTH-1:0]}};
    assign s_axi.bresp = {NUM_PORTS{m_axi.bresp}};
    assign b_hs        = m_axi.bvalid && m_axi.bready && b_port_ok;

    always_comb begin
        b_dec = '0;
        if (b_hs) b_dec[b_port] = 1'b1;
    end

    // A grant and a response for the same port in one cycle cancel out.
    always_comb begin
        idle_d = (state_d == ST_IDLE);
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (grant_oh[p] && !b_dec[p]) cnt_d[p] = cnt_q[p] + CNT_W'(1);
            else if (!grant_oh[p] && b_dec[p]) cnt_d[p] = cnt_q[p] - CNT_W'(1);
            if (cnt_d[p] != '0) idle_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            ptr_q     <= PORT_LG'(NUM_PORTS - 1);
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            idle_q    <= 1'b1;
            for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            idle_q    <= idle_d;
            for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= cnt_d[p];
            if (grant_fire) begin
                ptr_q    <= grant_idx;
                awid_q   <= {grant_idx, s_axi.awid[int'(grant_idx)*ID_WIDTH +: ID_WIDTH]};
                awaddr_q <= s_axi.awaddr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q  <= s_axi.wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                wstrb_q  <= s_axi.wstrb[int'(grant_idx)*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    assign m_axi.awid    = awid_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = AXSIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = wvalid_q;
    assign idle          = idle_q;
endmodule
